// File: rtl/coin_accumulator.sv
// Purpose: upstream credit stage of the soda machine; accumulates coin credit in 5-cent units.
// Latency: coin to summ 1 cycle; dispense/cancel to change pulse 1 cycle; one lock-out cycle after a vend.
// Backpressure: none upstream; coins that cannot be taken are returned via a registered coin_reject pulse.
module coin_accumulator #(
    parameter int PRICE = 5,
    parameter int W     = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         coin_valid,
    input  logic [1:0]   coin_type,
    input  logic         cancel,
    input  logic         M,
    output logic [W-1:0] summ,
    output logic [W-1:0] change,
    output logic         change_valid,
    output logic         coin_reject,
    output logic         busy
);

    typedef enum logic {
        COLLECT = 1'b0,
        VEND    = 1'b1
    } state_t;

    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;

    // Largest credit the register can hold, expressed at the widened sum width.
    localparam logic [W:0]   MAX_CREDIT = {1'b0, {W{1'b1}}};
    localparam logic [W-1:0] PRICE_W    = W'(PRICE);

    state_t       state;
    logic [W-1:0] coin_val;
    logic         coin_known;
    logic [W:0]   sum_ext;
    logic         coin_fits;

    // Decode the coin denomination; a slug has no value and is flagged unknown.
    always_comb begin
        coin_val   = '0;
        coin_known = 1'b1;
        case (coin_type)
            COIN_NICKEL:  coin_val = W'(1);
            COIN_DIME:    coin_val = W'(2);
            COIN_QUARTER: coin_val = W'(5);
            default:      coin_known = 1'b0;
        endcase
    end

    // Sum one bit wider than the credit so an overflowing coin is detected rather than wrapped.
    always_comb begin
        sum_ext   = {1'b0, summ} + {1'b0, coin_val};
        coin_fits = coin_known && (sum_ext <= MAX_CREDIT);
    end

    // Credit FSM: vend beats cancel beats coin; all outputs registered, pulses self-clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= COLLECT;
            summ         <= '0;
            change       <= '0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            case (state)
                COLLECT: begin
                    if (M) begin
                        // Downstream decided to dispense: hand back the excess and lock out coins.
                        summ         <= '0;
                        change       <= summ - PRICE_W;
                        change_valid <= 1'b1;
                        coin_reject  <= coin_valid;
                        state        <= VEND;
                    end else if (cancel) begin
                        // Full refund; no pulse when there is nothing to return.
                        summ        <= '0;
                        coin_reject <= coin_valid;
                        if (summ != '0) begin
                            change       <= summ;
                            change_valid <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (coin_fits) begin
                            summ <= sum_ext[W-1:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    // Single lock-out cycle while the item drops.
                    summ        <= '0;
                    coin_reject <= coin_valid;
                    state       <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    // busy simply reflects the registered state, so it is glitch-free.
    always_comb begin
        busy = (state == VEND);
    end

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed vector bench for coin_accumulator.
// Each vector drives inputs for one rising edge and checks all outputs 1 time unit later.
// M is driven by the bench so the dispense decision can be held low where needed.
module tb_coin_accumulator;

    localparam int W = 4;

    logic         CLK;
    logic         reset;
    logic         coin_valid;
    logic [1:0]   coin_type;
    logic         cancel;
    logic         M;
    logic [W-1:0] summ;
    logic [W-1:0] change;
    logic         change_valid;
    logic         coin_reject;
    logic         busy;

    coin_accumulator #(.PRICE(5), .W(W)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .cancel       (cancel),
        .M            (M),
        .summ         (summ),
        .change       (change),
        .change_valid (change_valid),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic         rst;
        logic         cv;
        logic [1:0]   ct;
        logic         can;
        logic         m;
        logic [W-1:0] e_summ;
        logic [W-1:0] e_change;
        logic         e_cvld;
        logic         e_rej;
        logic         e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_miscompares;

    localparam logic [1:0] NK = 2'b00;
    localparam logic [1:0] DM = 2'b01;
    localparam logic [1:0] QT = 2'b10;
    localparam logic [1:0] SL = 2'b11;

    function automatic vec_t mk(input logic rst, input logic cv, input logic [1:0] ct,
                                input logic can, input logic m,
                                input int es, input int ec, input logic ecv,
                                input logic erj, input logic eb);
        vec_t v;
        v.rst      = rst;
        v.cv       = cv;
        v.ct       = ct;
        v.can      = can;
        v.m        = m;
        v.e_summ   = W'(es);
        v.e_change = W'(ec);
        v.e_cvld   = ecv;
        v.e_rej    = erj;
        v.e_busy   = eb;
        return v;
    endfunction

    // Drive one vector across a rising edge, then compare every output against it.
    task automatic apply(input vec_t v, input string name);
        reset      = v.rst;
        coin_valid = v.cv;
        coin_type  = v.ct;
        cancel     = v.can;
        M          = v.m;
        @(posedge CLK);
        #1;
        n_applied++;
        if (summ !== v.e_summ || change !== v.e_change || change_valid !== v.e_cvld ||
            coin_reject !== v.e_rej || busy !== v.e_busy) begin
            n_miscompares++;
            $display("FAIL %s: got summ=%0d change=%0d change_valid=%0b coin_reject=%0b busy=%0b, want summ=%0d change=%0d change_valid=%0b coin_reject=%0b busy=%0b",
                     name, summ, change, change_valid, coin_reject, busy,
                     v.e_summ, v.e_change, v.e_cvld, v.e_rej, v.e_busy);
        end
    endtask

    initial begin
        n_applied     = 0;
        n_miscompares = 0;
        reset         = 1'b1;
        coin_valid    = 1'b0;
        coin_type     = NK;
        cancel        = 1'b0;
        M             = 1'b0;

        //                rst cv ct  can m   summ chg cvld rej busy
        // reset
        vecs.push_back(mk(1, 0, NK, 0, 0,   0,   0,  0,   0,  0));
        // quarter then vend with no change
        vecs.push_back(mk(0, 1, QT, 0, 0,   5,   0,  0,   0,  0));
        vecs.push_back(mk(0, 0, NK, 0, 1,   0,   0,  1,   0,  1));
        vecs.push_back(mk(0, 0, NK, 0, 0,   0,   0,  0,   0,  0));
        // dime, dime, nickel -> 2,4,5; vend change 0
        vecs.push_back(mk(0, 1, DM, 0, 0,   2,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, DM, 0, 0,   4,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, NK, 0, 0,   5,   0,  0,   0,  0));
        vecs.push_back(mk(0, 0, NK, 0, 1,   0,   0,  1,   0,  1));
        vecs.push_back(mk(0, 0, NK, 0, 0,   0,   0,  0,   0,  0));
        // dime x3 -> 6; vend change 1, change then holds
        vecs.push_back(mk(0, 1, DM, 0, 0,   2,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, DM, 0, 0,   4,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, DM, 0, 0,   6,   0,  0,   0,  0));
        vecs.push_back(mk(0, 0, NK, 0, 1,   0,   1,  1,   0,  1));
        vecs.push_back(mk(0, 0, NK, 0, 0,   0,   1,  0,   0,  0));
        // coin during the VEND cycle is rejected
        vecs.push_back(mk(0, 1, QT, 0, 0,   5,   1,  0,   0,  0));
        vecs.push_back(mk(0, 0, NK, 0, 1,   0,   0,  1,   0,  1));
        vecs.push_back(mk(0, 1, NK, 0, 0,   0,   0,  0,   1,  0));
        vecs.push_back(mk(0, 0, NK, 0, 0,   0,   0,  0,   0,  0));
        // coin on the same edge as M=1 is rejected
        vecs.push_back(mk(0, 1, QT, 0, 0,   5,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, NK, 0, 1,   0,   0,  1,   1,  1));
        vecs.push_back(mk(0, 0, NK, 0, 0,   0,   0,  0,   0,  0));
        // slug rejected, credit unchanged
        vecs.push_back(mk(0, 1, DM, 0, 0,   2,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, SL, 0, 0,   2,   0,  0,   1,  0));
        vecs.push_back(mk(0, 0, NK, 0, 0,   2,   0,  0,   0,  0));
        // M held low: build to 14, dime overflows, nickel reaches 15, next nickel overflows
        vecs.push_back(mk(0, 1, QT, 0, 0,   7,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, QT, 0, 0,  12,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, DM, 0, 0,  14,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, DM, 0, 0,  14,   0,  0,   1,  0));
        vecs.push_back(mk(0, 1, NK, 0, 0,  15,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, NK, 0, 0,  15,   0,  0,   1,  0));
        vecs.push_back(mk(0, 0, NK, 1, 0,   0,  15,  1,   0,  0));
        vecs.push_back(mk(0, 0, NK, 0, 0,   0,  15,  0,   0,  0));
        // nickel, dime, cancel -> refund 3; cancel at zero gives no pulse
        vecs.push_back(mk(0, 1, NK, 0, 0,   1,  15,  0,   0,  0));
        vecs.push_back(mk(0, 1, DM, 0, 0,   3,  15,  0,   0,  0));
        vecs.push_back(mk(0, 0, NK, 1, 0,   0,   3,  1,   0,  0));
        vecs.push_back(mk(0, 0, NK, 1, 0,   0,   3,  0,   0,  0));
        vecs.push_back(mk(0, 1, NK, 1, 0,   0,   3,  0,   1,  0));
        // cancel together with M=1: vend wins, change = 7-5
        vecs.push_back(mk(0, 1, QT, 0, 0,   5,   3,  0,   0,  0));
        vecs.push_back(mk(0, 1, DM, 0, 0,   7,   3,  0,   0,  0));
        vecs.push_back(mk(0, 0, NK, 1, 1,   0,   2,  1,   0,  1));
        vecs.push_back(mk(0, 0, NK, 1, 0,   0,   2,  0,   0,  0));
        // reset on the M=1 edge abandons the vend
        vecs.push_back(mk(0, 1, QT, 0, 0,   5,   2,  0,   0,  0));
        vecs.push_back(mk(1, 0, NK, 0, 1,   0,   0,  0,   0,  0));
        vecs.push_back(mk(0, 1, NK, 0, 0,   1,   0,  0,   0,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset landing in the VEND cycle with a coin and cancel present clears everything.
        apply(mk(0, 1, QT, 0, 0, 6, 0, 0, 0, 0), "rstvend_load");
        apply(mk(0, 0, NK, 0, 1, 0, 1, 1, 0, 1), "rstvend_vend");
        apply(mk(1, 1, DM, 1, 0, 0, 0, 0, 0, 0), "rstvend_reset");
        apply(mk(0, 1, DM, 0, 0, 2, 0, 0, 0, 0), "rstvend_after");

        // Back-to-back vends: coin in lock-out cycle rejected, coin one cycle later accepted.
        apply(mk(0, 1, QT, 0, 0, 7, 0, 0, 0, 0), "b2b_load");
        apply(mk(0, 0, NK, 0, 1, 0, 2, 1, 0, 1), "b2b_vend");
        apply(mk(0, 1, QT, 0, 0, 0, 2, 0, 1, 0), "b2b_locked");
        apply(mk(0, 1, QT, 0, 0, 5, 2, 0, 0, 0), "b2b_accept");
        apply(mk(0, 0, NK, 0, 1, 0, 0, 1, 0, 1), "b2b_vend2");
        apply(mk(0, 0, NK, 0, 0, 0, 0, 0, 0, 0), "b2b_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
